keys_debounce: RTL and testbench

KEYS_DEBOUNCE -- requirements
Module: keys_debounce

---
 rtl/keys_debounce.sv | 100 ++++++++++
 tb/tb_keys_debounce.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/keys_debounce.sv
// Key matrix debouncer: 2-flop synchroniser, shared sample-tick prescaler and a
// per-key integrator that accepts a new level after DEBOUNCE_TICKS disagreeing ticks.
module keys_debounce #(
   parameter int NUM_KEYS       = 61,
   parameter int PRESCALE       = 92000,
   parameter int DEBOUNCE_TICKS = 5
) (
   input  logic                clk_g_i,
   input  logic                rstn_g_i,
   input  logic [NUM_KEYS-1:0] keys_i_g,
   output logic [NUM_KEYS-1:0] keys_o,
   output logic                keys_changed_o,
   output logic                tick_o
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

   logic [NUM_KEYS-1:0] r_sync1;
   logic [NUM_KEYS-1:0] r_sync2;
   logic [NUM_KEYS-1:0] r_keys;
   logic [PW-1:0]       r_pre;
   logic                r_tick;
   logic                r_changed;
   logic [CW-1:0]       r_int [NUM_KEYS];

   logic [PW-1:0]       w_pre_next;
   logic [NUM_KEYS-1:0] w_keys_next;
   logic [CW-1:0]       w_int_next [NUM_KEYS];
   logic                w_any_flip;

   // Prescaler next count, wrapping at PRESCALE-1
   always_comb begin
      if (r_pre == PRE_LAST) begin
         w_pre_next = '0;
      end else begin
         w_pre_next = r_pre + PW'(1);
      end
   end

   // Per-key integrators; any agreeing tick restarts the count
   always_comb begin
      w_keys_next = r_keys;
      for (int k = 0; k < NUM_KEYS; k++) begin
         w_int_next[k] = r_int[k];
         if (r_tick) begin
            if (r_sync2[k] == r_keys[k]) begin
               w_int_next[k] = '0;
            end else if (r_int[k] == CNT_LAST) begin
               w_int_next[k]  = '0;
               w_keys_next[k] = r_sync2[k];
            end else begin
               w_int_next[k] = r_int[k] + CW'(1);
            end
         end else begin
            w_int_next[k] = r_int[k];
         end
      end
      w_any_flip = |(w_keys_next ^ r_keys);
   end

   // Synchroniser and prescaler; tick is registered so it is high exactly while count == PRESCALE-1
   always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
      if (!rstn_g_i) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
         r_pre   <= '0;
         r_tick  <= 1'b0;
      end else begin
         r_sync1 <= keys_i_g;
         r_sync2 <= r_sync1;
         r_pre   <= w_pre_next;
         r_tick  <= (w_pre_next == PRE_LAST);
      end
   end

   // Debounced levels, integrator state and change strobe
   always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
      if (!rstn_g_i) begin
         r_keys    <= '1;
         r_changed <= 1'b0;
         for (int k = 0; k < NUM_KEYS; k++) begin
            r_int[k] <= '0;
         end
      end else begin
         r_keys    <= w_keys_next;
         r_changed <= r_tick & w_any_flip;
         for (int k = 0; k < NUM_KEYS; k++) begin
            r_int[k] <= w_int_next[k];
         end
      end
   end

   assign keys_o         = r_keys;
   assign keys_changed_o = r_changed;
   assign tick_o         = r_tick;

endmodule

// File: tb/tb_keys_debounce.sv
// Directed bench for keys_debounce: slow instance (PRESCALE=4, DEBOUNCE_TICKS=3)
// and fast instance (PRESCALE=1, DEBOUNCE_TICKS=1) sharing clock and reset.
module tb_keys_debounce;

   localparam logic [60:0] ONES = {61{1'b1}};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [60:0] keys = ONES;
   logic [60:0] f_keys = ONES;
   logic [60:0] d_keys_o;
   logic        d_changed;
   logic        d_tick;
   logic [60:0] f_keys_o;
   logic        f_changed;
   logic        f_tick;
   int          checks = 0;
   int          errors = 0;
   int          cyc;
   logic [60:0] exp;
   logic [60:0] nxt;

   keys_debounce #(.NUM_KEYS(61), .PRESCALE(4), .DEBOUNCE_TICKS(3)) u_dut (
      .clk_g_i(clk), .rstn_g_i(rst_n), .keys_i_g(keys),
      .keys_o(d_keys_o), .keys_changed_o(d_changed), .tick_o(d_tick)
   );

   keys_debounce #(.NUM_KEYS(61), .PRESCALE(1), .DEBOUNCE_TICKS(1)) u_fast (
      .clk_g_i(clk), .rstn_g_i(rst_n), .keys_i_g(f_keys),
      .keys_o(f_keys_o), .keys_changed_o(f_changed), .tick_o(f_tick)
   );

   always #5 clk = ~clk;

   // Edges since reset release; ticks are consumed on edges where cyc % 4 == 0
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic align();
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while ((cyc % 4 != 0) && (n < 8));
      checks++;
      if (cyc % 4 != 0) begin
         errors++;
         $display("FAIL align cyc=%0d required multiple of 4", cyc);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (d_keys_o !== ONES || d_changed !== 1'b0 || d_tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_state keys=%h chg=%b tick=%b required all ones,0,0", d_keys_o, d_changed, d_tick);
      end
      checks++;
      if (f_keys_o !== ONES || f_changed !== 1'b0 || f_tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_state_fast keys=%h chg=%b tick=%b required all ones,0,0", f_keys_o, f_changed, f_tick);
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         checks++;
         if (d_tick !== ((k % 4) == 3) || d_changed !== 1'b0 || d_keys_o !== ONES) begin
            errors++;
            $display("FAIL tick_period edge=%0d tick=%b chg=%b keys=%h required tick=%b chg=0 keys all ones",
                     k, d_tick, d_changed, d_keys_o, ((k % 4) == 3));
         end
         checks++;
         if (f_tick !== 1'b1) begin
            errors++;
            $display("FAIL tick_fast edge=%0d tick=%b required 1", k, f_tick);
         end
      end
   endtask

   task automatic test_clean_press();
      align();
      keys[0] = 1'b0;
      nxt = ONES;
      nxt[0] = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #1;
         exp = (i >= 12) ? nxt : ONES;
         checks++;
         if (d_keys_o !== exp || d_changed !== (i == 12)) begin
            errors++;
            $display("FAIL clean_press edge=%0d keys=%h chg=%b required keys=%h chg=%b",
                     i, d_keys_o, d_changed, exp, (i == 12));
         end
      end
   endtask

   task automatic test_release();
      align();
      keys[0] = 1'b1;
      nxt = ONES;
      nxt[0] = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #1;
         exp = (i >= 12) ? ONES : nxt;
         checks++;
         if (d_keys_o !== exp || d_changed !== (i == 12)) begin
            errors++;
            $display("FAIL release edge=%0d keys=%h chg=%b required keys=%h chg=%b",
                     i, d_keys_o, d_changed, exp, (i == 12));
         end
      end
   endtask

   task automatic test_glitch();
      align();
      keys[5] = 1'b0;
      for (int i = 1; i <= 28; i++) begin
         @(posedge clk); #1;
         checks++;
         if (d_keys_o !== ONES || d_changed !== 1'b0) begin
            errors++;
            $display("FAIL glitch edge=%0d keys=%h chg=%b required all ones,0", i, d_keys_o, d_changed);
         end
         if (i == 8)  keys[5] = 1'b1;
         if (i == 12) keys[5] = 1'b0;
         if (i == 20) keys[5] = 1'b1;
      end
   endtask

   task automatic test_simultaneous();
      align();
      keys[0] = 1'b0;
      keys[30] = 1'b0;
      keys[60] = 1'b0;
      nxt = ONES;
      nxt[0] = 1'b0;
      nxt[30] = 1'b0;
      nxt[60] = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #1;
         exp = (i >= 12) ? nxt : ONES;
         checks++;
         if (d_keys_o !== exp || d_changed !== (i == 12)) begin
            errors++;
            $display("FAIL simultaneous edge=%0d keys=%h chg=%b required keys=%h chg=%b",
                     i, d_keys_o, d_changed, exp, (i == 12));
         end
      end
   endtask

   task automatic test_mid_reset();
      align();
      keys[7] = 1'b0;
      exp = ONES;
      exp[0] = 1'b0;
      exp[30] = 1'b0;
      exp[60] = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         @(posedge clk); #1;
         checks++;
         if (d_keys_o !== exp || d_changed !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_pre edge=%0d keys=%h chg=%b required keys=%h chg=0", i, d_keys_o, d_changed, exp);
         end
      end
      rst_n = 1'b0;
      #2;
      checks++;
      if (d_keys_o !== ONES || d_changed !== 1'b0 || d_tick !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_async keys=%h chg=%b tick=%b required all ones,0,0", d_keys_o, d_changed, d_tick);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      nxt = exp;
      nxt[7] = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #1;
         exp = (i >= 12) ? nxt : ONES;
         checks++;
         if (d_keys_o !== exp || d_changed !== (i == 12)) begin
            errors++;
            $display("FAIL mid_reset_post edge=%0d keys=%h chg=%b required keys=%h chg=%b",
                     i, d_keys_o, d_changed, exp, (i == 12));
         end
      end
   endtask

   task automatic test_fast();
      nxt = ONES;
      nxt[3] = 1'b0;
      @(posedge clk); #1;
      f_keys[3] = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk); #1;
         exp = (i >= 3) ? nxt : ONES;
         checks++;
         if (f_keys_o !== exp || f_changed !== (i == 3) || f_tick !== 1'b1) begin
            errors++;
            $display("FAIL fast_press edge=%0d keys=%h chg=%b tick=%b required keys=%h chg=%b tick=1",
                     i, f_keys_o, f_changed, f_tick, exp, (i == 3));
         end
      end
      f_keys[3] = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk); #1;
         exp = (i >= 3) ? ONES : nxt;
         checks++;
         if (f_keys_o !== exp || f_changed !== (i == 3)) begin
            errors++;
            $display("FAIL fast_release edge=%0d keys=%h chg=%b required keys=%h chg=%b",
                     i, f_keys_o, f_changed, exp, (i == 3));
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_release();
      test_glitch();
      test_simultaneous();
      test_mid_reset();
      test_fast();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
